// File: rtl/simon_word_loader_if.sv
// Host-side word bus of the SIMON word loader: an input word stream toward the
// loader and an output cipher-word stream back to the host.
interface simon_word_loader_if #(
  parameter int N = 16
);
  logic         in_valid;
  logic         in_ready;
  logic         in_sel;
  logic [N-1:0] in_word;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_word;

  modport master (
    output in_valid, in_sel, in_word, out_ready,
    input  in_ready, out_valid, out_word
  );

  modport slave (
    input  in_valid, in_sel, in_word, out_ready,
    output in_ready, out_valid, out_word
  );
endinterface

// File: rtl/simon_word_loader.sv
// Word-serial front-end for the SIMON 32/64 core: assembles plaintext and key
// from host words, hands them to the core, and streams the cipher back.
module simon_word_loader #(
  parameter int N = 16,
  parameter int M = 4
) (
  input  logic                 clk,
  input  logic                 nR,
  simon_word_loader_if.slave   host,
  output logic [2*N-1:0]       plain,
  output logic [M*N-1:0]       key,
  output logic                 newData,
  output logic                 newKey,
  input  logic                 ldData,
  input  logic                 ldKey,
  input  logic                 doneData,
  output logic                 readData,
  input  logic [2*N-1:0]       cipher
);

  localparam int KW = (M > 1) ? $clog2(M) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CAP  = 2'd1;
  localparam logic [1:0] S_W0   = 2'd2;
  localparam logic [1:0] S_W1   = 2'd3;

  logic           dcnt_q, dcnt_d;
  logic [KW-1:0]  kcnt_q, kcnt_d;
  logic [2*N-1:0] plain_q, plain_d;
  logic [M*N-1:0] key_q, key_d;
  logic           new_data_q, new_data_d;
  logic           new_key_q, new_key_d;
  logic           d_held_q, d_held_d;
  logic [1:0]     state_q, state_d;
  logic [2*N-1:0] obuf_q, obuf_d;

  logic xfer_d, xfer_k, last_d, last_k, key_quiet;

  // A completed plaintext waiting behind a key blocks further plaintext words
  // just like a pending one does.
  assign host.in_ready = host.in_sel ? ~new_key_q : ~(new_data_q | d_held_q);
  assign xfer_d        = host.in_valid & host.in_ready & ~host.in_sel;
  assign xfer_k        = host.in_valid & host.in_ready &  host.in_sel;
  assign last_d        = xfer_d & dcnt_q;
  assign last_k        = xfer_k & (kcnt_q == KW'(M - 1));
  assign key_quiet     = ~new_key_q & (kcnt_q == '0);

  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    dcnt_d     = dcnt_q;
    kcnt_d     = kcnt_q;
    plain_d    = plain_q;
    key_d      = key_q;
    new_data_d = new_data_q;
    new_key_d  = new_key_q;
    d_held_d   = d_held_q;

    if (xfer_d) begin
      if (dcnt_q) plain_d[2*N-1:N] = host.in_word;
      else        plain_d[N-1:0]   = host.in_word;
      dcnt_d = ~dcnt_q;
    end

    if (xfer_k) begin
      key_d[kcnt_q*N +: N] = host.in_word;
      kcnt_d = last_k ? '0 : kcnt_q + KW'(1);
    end

    if (last_k)                   new_key_d = 1'b1;
    else if (ldKey && new_key_q)  new_key_d = 1'b0;

    // Plaintext is only offered once no key is pending or half-assembled.
    if (last_d) begin
      if (key_quiet) new_data_d = 1'b1;
      else           d_held_d   = 1'b1;
    end else if (d_held_q && key_quiet) begin
      d_held_d   = 1'b0;
      new_data_d = 1'b1;
    end else if (ldData && new_data_q) begin
      new_data_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    obuf_d  = obuf_q;
    unique case (state_q)
      S_IDLE: if (doneData) state_d = S_CAP;
      S_CAP: begin
        obuf_d  = cipher;
        state_d = S_W0;
      end
      S_W0:   if (host.out_ready) state_d = S_W1;
      S_W1:   if (host.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nR) begin
    if (!nR) begin
      dcnt_q     <= 1'b0;
      kcnt_q     <= '0;
      plain_q    <= '0;
      key_q      <= '0;
      new_data_q <= 1'b0;
      new_key_q  <= 1'b0;
      d_held_q   <= 1'b0;
      state_q    <= S_IDLE;
      obuf_q     <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      dcnt_q     <= dcnt_d;
      kcnt_q     <= kcnt_d;
      plain_q    <= plain_d;
      key_q      <= key_d;
      new_data_q <= new_data_d;
      new_key_q  <= new_key_d;
      d_held_q   <= d_held_d;
      state_q    <= state_d;
      obuf_q     <= obuf_d;
    end
  end

  assign plain          = plain_q;
  assign key            = key_q;
  assign newData        = new_data_q;
  assign newKey         = new_key_q;
  assign readData       = (state_q == S_CAP);
  assign host.out_valid = (state_q == S_W0) || (state_q == S_W1);
  assign host.out_word  = (state_q == S_W0) ? obuf_q[N-1:0] :
                          (state_q == S_W1) ? obuf_q[2*N-1:N] : '0;

endmodule

// File: tb/tb_simon_word_loader.sv
// Bench for simon_word_loader: directed handshake scenarios, then randomized
// traffic checked by queue-based scoreboards against a word-level model.
module tb_simon_word_loader;
  localparam int N = 16;
  localparam int M = 4;

  logic           clk = 1'b0;
  logic           nR  = 1'b0;
  logic [2*N-1:0] plain;
  logic [M*N-1:0] key;
  logic           newData, newKey, readData;
  logic           ldData = 1'b0, ldKey = 1'b0, doneData = 1'b0;
  logic [2*N-1:0] cipher = '0;

  simon_word_loader_if #(.N(N)) host ();

  simon_word_loader #(.N(N), .M(M)) dut (
    .clk      (clk),
    .nR       (nR),
    .host     (host),
    .plain    (plain),
    .key      (key),
    .newData  (newData),
    .newKey   (newKey),
    .ldData   (ldData),
    .ldKey    (ldKey),
    .doneData (doneData),
    .readData (readData),
    .cipher   (cipher)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  bit rand_on    = 1'b0;
  bit rand_done  = 1'b0;

  logic [2*N-1:0] exp_plain[$];
  logic [M*N-1:0] exp_key[$];
  logic [N-1:0]   exp_out[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One host word; waits for in_ready with a bound, transfer on the next posedge.
  task automatic send_word(input bit sel, input logic [N-1:0] w);
    int g = 0;
    @(negedge clk);
    host.in_sel   = sel;
    host.in_word  = w;
    host.in_valid = 1'b1;
    #1;
    while (!host.in_ready && g < 200) begin
      @(negedge clk); #1;
      g++;
    end
    check("send_word_ready", 64'(host.in_ready), 64'(1));
    @(posedge clk); #1;
    host.in_valid = 1'b0;
  endtask

  task automatic pulse(input bit is_key);
    @(negedge clk);
    if (is_key) ldKey = 1'b1; else ldData = 1'b1;
    @(posedge clk); #1;
    ldKey  = 1'b0;
    ldData = 1'b0;
  endtask

  task automatic drive_random(input int n_plain, input int n_key);
    int pi = 0, ki = 0, pdone = 0, kdone = 0, stall = 0, cyc = 0;
    bit sel;
    logic [2*N-1:0] cp;
    logic [M*N-1:0] ck;
    cp = $urandom();
    ck = {$urandom(), $urandom()};
    while ((pdone < n_plain || kdone < n_key) && stall < 3000 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if ($urandom_range(0, 3) == 0) continue;
      if (pdone >= n_plain)     sel = 1'b1;
      else if (kdone >= n_key)  sel = 1'b0;
      else                      sel = 1'($urandom_range(0, 1));
      host.in_sel = sel; #1;
      if (!host.in_ready && pdone < n_plain && kdone < n_key) begin
        sel = ~sel;
        host.in_sel = sel; #1;
      end
      if (!host.in_ready) begin
        stall++;
        continue;
      end
      stall = 0;
      host.in_word  = sel ? ck[ki*N +: N] : cp[pi*N +: N];
      host.in_valid = 1'b1;
      @(posedge clk); #1;
      host.in_valid = 1'b0;
      if (sel) begin
        if (ki == M - 1) begin
          exp_key.push_back(ck);
          ck = {$urandom(), $urandom()};
          ki = 0;
          kdone++;
        end else ki++;
      end else begin
        if (pi == 1) begin
          exp_plain.push_back(cp);
          cp = $urandom();
          pi = 0;
          pdone++;
        end else pi++;
      end
    end
    check("drive_progress", 64'(pdone == n_plain && kdone == n_key), 64'(1));
  endtask

  task automatic drive_cipher(input int n);
    int g;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(1, 8)) @(negedge clk);
      cipher = $urandom();
      exp_out.push_back(cipher[N-1:0]);
      exp_out.push_back(cipher[2*N-1:N]);
      doneData = 1'b1;
      g = 0;
      do begin
        @(negedge clk);
        g++;
      end while (!readData && g < 100);
      check("readdata_seen", 64'(readData), 64'(1));
      doneData = 1'b0;
    end
  endtask

  // Core model: acknowledges pending plaintext/key after a random delay and
  // checks the presented value against the scoreboard.
  initial begin
    wait (rand_on);
    while (!rand_done) begin
      @(negedge clk);
      if (ldData) ldData = 1'b0;
      else if (newData && $urandom_range(0, 2) == 0) begin
        check("plain_q_nonempty", 64'(exp_plain.size() != 0), 64'(1));
        if (exp_plain.size() != 0) check("plain_value", 64'(plain), 64'(exp_plain.pop_front()));
        ldData = 1'b1;
      end
    end
    ldData = 1'b0;
  end

  initial begin
    wait (rand_on);
    while (!rand_done) begin
      @(negedge clk);
      if (ldKey) ldKey = 1'b0;
      else if (newKey && $urandom_range(0, 2) == 0) begin
        check("key_q_nonempty", 64'(exp_key.size() != 0), 64'(1));
        if (exp_key.size() != 0) check("key_value", key, exp_key.pop_front());
        ldKey = 1'b1;
      end
    end
    ldKey = 1'b0;
  end

  // Host receiver: random backpressure, every presented word compared.
  initial begin
    wait (rand_on);
    while (!rand_done) begin
      @(negedge clk);
      host.out_ready = 1'($urandom_range(0, 1));
      if (host.out_valid) begin
        check("out_q_nonempty", 64'(exp_out.size() != 0), 64'(1));
        if (exp_out.size() != 0) begin
          check("out_word", 64'(host.out_word), 64'(exp_out[0]));
          if (host.out_ready) void'(exp_out.pop_front());
        end
      end
    end
    host.out_ready = 1'b0;
  end

  // Protocol watchers: plaintext never offered over a pending key; readData is one cycle.
  initial begin
    bit prev_nd = 1'b0, prev_rd = 1'b0;
    forever begin
      @(negedge clk);
      if (newData && !prev_nd) check("order_newkey_low", 64'(newKey), 64'(0));
      if (readData) check("readdata_width", 64'(prev_rd), 64'(0));
      prev_nd = newData;
      prev_rd = readData;
    end
  end

  initial begin
    int g;
    host.in_valid  = 1'b0;
    host.in_sel    = 1'b0;
    host.in_word   = '0;
    host.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    nR = 1'b1;
    #1;
    check("rst_in_ready", 64'(host.in_ready), 64'(1));
    check("rst_newData", 64'(newData), 64'(0));
    check("rst_newKey", 64'(newKey), 64'(0));
    check("rst_plain", 64'(plain), 64'(0));
    check("rst_key", key, 64'(0));
    check("rst_out_valid", 64'(host.out_valid), 64'(0));
    check("rst_out_word", 64'(host.out_word), 64'(0));
    check("rst_readData", 64'(readData), 64'(0));

    // Reset during key assembly drops the partial key.
    send_word(1'b1, 16'h0100);
    send_word(1'b1, 16'h0908);
    @(negedge clk);
    nR = 1'b0;
    #2;
    check("midrst_key", key, 64'(0));
    check("midrst_newKey", 64'(newKey), 64'(0));
    check("midrst_in_ready", 64'(host.in_ready), 64'(1));
    #2;
    nR = 1'b1;

    send_word(1'b1, 16'h0100);
    send_word(1'b1, 16'h0908);
    send_word(1'b1, 16'h1110);
    check("key_not_early", 64'(newKey), 64'(0));
    send_word(1'b1, 16'h1918);
    check("key_newKey", 64'(newKey), 64'(1));
    check("key_value_dir", key, 64'h1918_1110_0908_0100);

    // Plaintext completes behind the pending key.
    send_word(1'b0, 16'h6877);
    send_word(1'b0, 16'h6565);
    check("plain_value_dir", 64'(plain), 64'h6565_6877);
    check("plain_held_newData", 64'(newData), 64'(0));
    check("plain_held_ready", 64'(host.in_ready), 64'(0));
    pulse(1'b1);
    check("ldkey_clears", 64'(newKey), 64'(0));
    check("ldkey_nd_still_low", 64'(newData), 64'(0));
    @(posedge clk); #1;
    check("nd_after_ldkey", 64'(newData), 64'(1));
    check("plain_ready_pending", 64'(host.in_ready), 64'(0));
    pulse(1'b0);
    check("lddata_clears", 64'(newData), 64'(0));
    check("plain_ready_after", 64'(host.in_ready), 64'(1));
    pulse(1'b1);
    check("ldkey_ignored", 64'(newKey), 64'(0));

    // Cipher capture and stalled output.
    @(negedge clk);
    cipher   = 32'hC69B_E9BB;
    doneData = 1'b1;
    @(negedge clk);
    check("cap_readData", 64'(readData), 64'(1));
    check("cap_out_valid", 64'(host.out_valid), 64'(0));
    doneData = 1'b0;
    @(negedge clk);
    check("w0_readData_low", 64'(readData), 64'(0));
    check("w0_valid", 64'(host.out_valid), 64'(1));
    check("w0_word", 64'(host.out_word), 64'hE9BB);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("w0_stall_word", 64'(host.out_word), 64'hE9BB);
    end
    host.out_ready = 1'b1;
    @(negedge clk);
    check("w1_valid", 64'(host.out_valid), 64'(1));
    check("w1_word", 64'(host.out_word), 64'hC69B);
    @(negedge clk);
    check("out_done_valid", 64'(host.out_valid), 64'(0));
    host.out_ready = 1'b0;

    // Randomized concurrent traffic on both paths.
    rand_on = 1'b1;
    fork
      drive_random(20, 8);
      drive_cipher(10);
    join
    g = 0;
    while ((exp_plain.size() != 0 || exp_key.size() != 0 || exp_out.size() != 0 ||
            newData || newKey || host.out_valid) && g < 1000) begin
      @(negedge clk);
      g++;
    end
    check("drain_plain", 64'(exp_plain.size()), 64'(0));
    check("drain_key", 64'(exp_key.size()), 64'(0));
    check("drain_out", 64'(exp_out.size()), 64'(0));
    rand_done = 1'b1;
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
